uart_tx_arbiter: RTL and testbench

Shares the single RS-232 transmit serializer between several byte producers, e.g. the CPU output port and a debug/trace port. It runs round-robin arbitration with optional multi-byte message locking, so one requester's message is never interleaved with another's. It issues one-byte `go` commands to the transmitter and waits for it to finish before granting again. The block sits between the requesters and the transmitter in `top`, ahead of RS_TX.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, arbiter FSM encoding,
// lock-timeout counter width and an index-width helper.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int TO_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAPW  = 3'd4
  } arb_state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: scans requests starting just after `last`
// (wrapping), so `last` itself has the lowest priority.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int GW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic            any,
  output logic [GW-1:0]   win
);

  always_comb begin
    any = 1'b0;
    win = last;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && req[(int'(last) + k) % NREQ]) begin
        any = 1'b1;
        win = GW'((int'(last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers,
// holding the grant across multi-byte messages with a timeout-forced release.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ         = 2,
  parameter  int GAP          = 0,
  parameter  int LOCK_TIMEOUT = 65535,
  localparam int GW           = idx_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_go,
  input  logic                   tx_busy,
  output logic [GW-1:0]          grant_id,
  output logic                   locked,
  output logic                   lock_abort
);

  localparam int              GAP_W    = idx_w(GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(LOCK_TIMEOUT);
  localparam logic [GW-1:0]    LAST_IDX = GW'(NREQ - 1);

  arb_state_t         state_reg, state_next;
  logic [GW-1:0]      grant_reg, grant_next;
  logic               first_reg, first_next;
  logic               locked_reg, locked_next;
  logic [BYTE_W-1:0]  data_reg, data_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;

  logic [BYTE_W-1:0]  req_byte [NREQ];
  logic               pick_any;
  logic [GW-1:0]      pick_win;
  logic               own_valid;
  logic               own_last;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_byte
    assign req_byte[gi] = req_data[gi*BYTE_W +: BYTE_W];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req_valid),
    .last (grant_reg),
    .any  (pick_any),
    .win  (pick_win)
  );

  assign own_valid = req_valid[grant_reg];
  assign own_last  = req_last[grant_reg];

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    first_next   = first_reg;
    locked_next  = locked_reg;
    data_next    = data_reg;
    to_cnt_next  = to_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    lock_abort   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (locked_reg) begin
          // Owner's byte beats a timeout landing in the same cycle.
          if (own_valid) begin
            data_next  = req_byte[grant_reg];
            state_next = ST_SEND;
          end else if (to_cnt_reg >= TO_LIM) begin
            locked_next = 1'b0;
            lock_abort  = 1'b1;
            to_cnt_next = '0;
          end else if (to_cnt_reg != '1) begin
            to_cnt_next = to_cnt_reg + 1'b1;
          end
        end else if (pick_any) begin
          grant_next = pick_win;
          first_next = 1'b0;
          data_next  = req_byte[pick_win];
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        locked_next = own_valid & ~own_last;
        to_cnt_next = '0;
        state_next  = ST_HOLD;
      end
      // Transmitter busy may only be rising now, so it is not sampled here.
      ST_HOLD:  state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!tx_busy) begin
          if (GAP > 0) begin
            gap_cnt_next = '0;
            state_next   = ST_GAPW;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_GAPW: begin
        if (gap_cnt_reg >= GAP_LAST) state_next = ST_IDLE;
        else                         gap_cnt_next = gap_cnt_reg + 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pointer resets to the top index so the first arbitration favours index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= LAST_IDX;
      first_reg   <= 1'b1;
      locked_reg  <= 1'b0;
      data_reg    <= '0;
      to_cnt_reg  <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      first_reg   <= first_next;
      locked_reg  <= locked_next;
      data_reg    <= data_next;
      to_cnt_reg  <= to_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  assign tx_go     = (state_reg == ST_SEND);
  assign req_ready = tx_go ? (NREQ'(1) << grant_reg) : '0;
  assign tx_data   = data_reg;
  assign grant_id  = first_reg ? '0 : grant_reg;
  assign locked    = locked_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: a GAP=0/timeout-10 arbiter with three requesters plus a
// GAP=3 two-requester instance, against message-level round-robin expectations.
module tb_uart_tx_arbiter;

  localparam int NA = 3;
  localparam int LT = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [NA-1:0] req_valid;
  logic [8*NA-1:0] req_data;
  logic [NA-1:0] req_last;

  logic [NA-1:0] rdy_a;
  logic [7:0]    txd_a;
  logic          go_a, busy_a, lck_a, abt_a;
  logic [1:0]    gid_a;

  logic [1:0]    rdy_b;
  logic [7:0]    txd_b;
  logic          go_b, busy_b, lck_b, abt_b;
  logic [0:0]    gid_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int busy_len = 20;
  bit busy_dly = 1'b0;
  logic go_d_a, go_d_b;
  int bcnt_a, bcnt_b;

  logic [8:0] src_q [NA][$];
  logic [7:0] got_d[$];
  int         got_id[$];
  int         got_cyc[$];
  logic       got_lck[$];
  logic [NA-1:0] got_rdy[$];
  logic       got_busy[$];
  int         abort_cyc[$];

  uart_tx_arbiter #(.NREQ(NA), .GAP(0), .LOCK_TIMEOUT(LT)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy_a), .tx_data(txd_a), .tx_go(go_a),
    .tx_busy(busy_a), .grant_id(gid_a), .locked(lck_a), .lock_abort(abt_a)
  );

  uart_tx_arbiter #(.NREQ(2), .GAP(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid[1:0]), .req_data(req_data[15:0]),
    .req_last(req_last[1:0]), .req_ready(rdy_b), .tx_data(txd_b), .tx_go(go_b),
    .tx_busy(busy_b), .grant_id(gid_b), .locked(lck_b), .lock_abort(abt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter models: busy for busy_len cycles, starting one or two edges after tx_go.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_a <= 1'b0; bcnt_a <= 0; go_d_a <= 1'b0;
    end else begin
      go_d_a <= go_a;
      if (busy_dly ? go_d_a : go_a) begin busy_a <= 1'b1; bcnt_a <= busy_len; end
      else if (bcnt_a > 1) bcnt_a <= bcnt_a - 1;
      else if (bcnt_a == 1) begin bcnt_a <= 0; busy_a <= 1'b0; end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_b <= 1'b0; bcnt_b <= 0; go_d_b <= 1'b0;
    end else begin
      go_d_b <= go_b;
      if (busy_dly ? go_d_b : go_b) begin busy_b <= 1'b1; bcnt_b <= busy_len; end
      else if (bcnt_b > 1) bcnt_b <= bcnt_b - 1;
      else if (bcnt_b == 1) begin bcnt_b <= 0; busy_b <= 1'b0; end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int r = 0; r < NA; r++) src_q[r].delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic present();
    logic [8:0] h;
    for (int r = 0; r < NA; r++) begin
      if (src_q[r].size() > 0) begin
        h = src_q[r][0];
        req_valid[r] = 1'b1;
        req_data[r*8 +: 8] = h[7:0];
        req_last[r] = h[8];
      end else begin
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
      end
    end
  endtask

  // Drives the source queues into dut_a and logs every byte it issues.
  task automatic run_traffic(input int want, input int max_cyc, output bit tmo);
    bit acc [NA];
    got_d.delete(); got_id.delete(); got_cyc.delete(); got_lck.delete();
    got_rdy.delete(); got_busy.delete(); abort_cyc.delete();
    present();
    tmo = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (go_a) begin
        got_d.push_back(txd_a); got_id.push_back(int'(gid_a)); got_cyc.push_back(cyc);
        got_lck.push_back(lck_a); got_rdy.push_back(rdy_a); got_busy.push_back(busy_a);
        $display("tx byte %h from req %0d at cycle %0d", txd_a, gid_a, cyc);
      end
      if (abt_a) abort_cyc.push_back(cyc);
      for (int r = 0; r < NA; r++) acc[r] = req_valid[r] && rdy_a[r];
      @(posedge clk);
      #1;
      for (int r = 0; r < NA; r++) if (acc[r]) void'(src_q[r].pop_front());
      present();
      if (got_d.size() >= want) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    #1;
    n_checks++; if (rdy_a !== '0)    begin n_errors++; $display("FAIL reset_ready: got %b, expected 000", rdy_a); end
    n_checks++; if (go_a !== 1'b0)   begin n_errors++; $display("FAIL reset_go: got %b, expected 0", go_a); end
    n_checks++; if (txd_a !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h, expected 00", txd_a); end
    n_checks++; if (gid_a !== 2'd0)  begin n_errors++; $display("FAIL reset_grant: got %0d, expected 0", gid_a); end
    n_checks++; if (lck_a !== 1'b0)  begin n_errors++; $display("FAIL reset_locked: got %b, expected 0", lck_a); end
    n_checks++; if (abt_a !== 1'b0)  begin n_errors++; $display("FAIL reset_abort: got %b, expected 0", abt_a); end
    n_checks++;
    if ({rdy_b, go_b, txd_b, gid_b, lck_b, abt_b} !== '0) begin
      n_errors++; $display("FAIL reset_b: got %h, expected 0", {rdy_b, go_b, txd_b, gid_b, lck_b, abt_b});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (go_a !== 1'b0) begin n_errors++; $display("FAIL idle_no_go: got %b, expected 0", go_a); end
  endtask

  task automatic test_single();
    bit tmo; int t0;
    do_reset();
    busy_len = 20; busy_dly = 1'b0;
    src_q[0].push_back({1'b1, 8'hA5});
    t0 = cyc;
    run_traffic(1, 60, tmo);
    n_checks++; if (tmo) begin n_errors++; $display("FAIL single_timeout: got 0 bytes, expected 1"); end
    else begin
      n_checks++; if (got_d[0] !== 8'hA5)    begin n_errors++; $display("FAIL single_data: got %h, expected a5", got_d[0]); end
      n_checks++; if (got_cyc[0] != t0 + 1)  begin n_errors++; $display("FAIL single_latency: got cycle %0d, expected %0d", got_cyc[0], t0 + 1); end
      n_checks++; if (got_rdy[0] !== 3'b001) begin n_errors++; $display("FAIL single_ready: got %b, expected 001", got_rdy[0]); end
      n_checks++; if (got_id[0] != 0)        begin n_errors++; $display("FAIL single_grant: got %0d, expected 0", got_id[0]); end
      n_checks++; if (lck_a !== 1'b0)        begin n_errors++; $display("FAIL single_locked: got %b, expected 0", lck_a); end
    end
  endtask

  task automatic test_contention();
    bit tmo;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h11; exp_d[3] = 8'h22;
    do_reset();
    busy_len = 4; busy_dly = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_q[0].push_back({1'b1, 8'h11});
      src_q[1].push_back({1'b1, 8'h22});
    end
    run_traffic(4, 200, tmo);
    n_checks++; if (tmo) begin n_errors++; $display("FAIL contention_timeout: got %0d bytes, expected 4", got_d.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_d[i] !== exp_d[i] || got_id[i] != (i % 2)) begin
        n_errors++;
        $display("FAIL contention_order[%0d]: got %h/req%0d, expected %h/req%0d", i, got_d[i], got_id[i], exp_d[i], i % 2);
      end
    end
  endtask

  task automatic test_lock();
    bit tmo;
    logic [7:0] exp_d [4];
    logic       exp_l [4];
    exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43; exp_d[3] = 8'h99;
    exp_l[0] = 1'b0;  exp_l[1] = 1'b1;  exp_l[2] = 1'b1;  exp_l[3] = 1'b0;
    do_reset();
    busy_len = 5; busy_dly = 1'b1;
    src_q[0].push_back({1'b0, 8'h41});
    src_q[0].push_back({1'b0, 8'h42});
    src_q[0].push_back({1'b1, 8'h43});
    src_q[1].push_back({1'b1, 8'h99});
    run_traffic(4, 200, tmo);
    n_checks++; if (tmo) begin n_errors++; $display("FAIL lock_timeout_run: got %0d bytes, expected 4", got_d.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_d[i] !== exp_d[i] || got_lck[i] !== exp_l[i]) begin
        n_errors++;
        $display("FAIL lock_seq[%0d]: got %h locked=%b, expected %h locked=%b", i, got_d[i], got_lck[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_lock_timeout();
    bit tmo;
    do_reset();
    busy_len = 20; busy_dly = 1'b0;
    src_q[0].push_back({1'b0, 8'h01});
    src_q[1].push_back({1'b1, 8'h02});
    run_traffic(2, 200, tmo);
    n_checks++; if (tmo) begin n_errors++; $display("FAIL abort_run: got %0d bytes, expected 2", got_d.size()); end
    else begin
      n_checks++;
      if (got_d[0] !== 8'h01 || got_d[1] !== 8'h02) begin
        n_errors++; $display("FAIL abort_order: got %h %h, expected 01 02", got_d[0], got_d[1]);
      end
      n_checks++;
      if (abort_cyc.size() != 1) begin
        n_errors++; $display("FAIL abort_count: got %0d pulses, expected 1", abort_cyc.size());
      end else begin
        // busy falls busy_len+1 edges after SEND, DRAIN sees it one edge later, then LT idle cycles
        n_checks++;
        if (abort_cyc[0] != got_cyc[0] + busy_len + 2 + LT) begin
          n_errors++; $display("FAIL abort_time: got cycle %0d, expected %0d", abort_cyc[0], got_cyc[0] + busy_len + 2 + LT);
        end
        n_checks++;
        if (got_cyc[1] != abort_cyc[0] + 2) begin
          n_errors++; $display("FAIL abort_regrant: got cycle %0d, expected %0d", got_cyc[1], abort_cyc[0] + 2);
        end
      end
    end
  endtask

  task automatic test_gap();
    int ga[$], gb[$], fa[$], fb[$];
    logic pa, pb;
    do_reset();
    busy_len = 6; busy_dly = 1'b0;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h5A; req_last[0] = 1'b1;
    pa = 1'b0; pb = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (go_a) ga.push_back(cyc);
      if (go_b) begin
        gb.push_back(cyc);
        $display("gap dut tx byte %h at cycle %0d", txd_b, cyc);
        n_checks++; if (txd_b !== 8'h5A) begin n_errors++; $display("FAIL gap_data: got %h, expected 5a", txd_b); end
      end
      if (pa && !busy_a) fa.push_back(cyc);
      if (pb && !busy_b) fb.push_back(cyc);
      pa = busy_a; pb = busy_b;
    end
    n_checks++;
    if (ga.size() < 2 || fa.size() < 1) begin
      n_errors++; $display("FAIL gap0_spacing: got %0d go pulses, expected at least 2", ga.size());
    end else if (ga[1] != fa[0] + 2) begin
      n_errors++; $display("FAIL gap0_spacing: got cycle %0d, expected %0d", ga[1], fa[0] + 2);
    end
    n_checks++;
    if (gb.size() < 2 || fb.size() < 1) begin
      n_errors++; $display("FAIL gap3_spacing: got %0d go pulses, expected at least 2", gb.size());
    end else if (gb[1] != fb[0] + 5) begin
      n_errors++; $display("FAIL gap3_spacing: got cycle %0d, expected %0d", gb[1], fb[0] + 5);
    end
  endtask

  task automatic test_async_reset();
    bit tmo; int t0;
    do_reset();
    busy_len = 20; busy_dly = 1'b0;
    src_q[1].push_back({1'b0, 8'h7E});
    run_traffic(1, 60, tmo);
    repeat (3) @(negedge clk);
    n_checks++;
    if (tmo || txd_a !== 8'h7E || gid_a !== 2'd1 || lck_a !== 1'b1) begin
      n_errors++; $display("FAIL pre_reset_state: got data %h grant %0d locked %b, expected 7e 1 1", txd_a, gid_a, lck_a);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({rdy_a, go_a, txd_a, gid_a, lck_a, abt_a} !== '0) begin
      n_errors++; $display("FAIL async_reset_outputs: got %h, expected 0", {rdy_a, go_a, txd_a, gid_a, lck_a, abt_a});
    end
    do_reset();
    src_q[1].push_back({1'b1, 8'h33});
    t0 = cyc;
    run_traffic(1, 60, tmo);
    n_checks++;
    if (tmo) begin n_errors++; $display("FAIL post_reset_run: got 0 bytes, expected 1"); end
    else if (got_d[0] !== 8'h33 || got_id[0] != 1 || got_rdy[0] !== 3'b010 || got_cyc[0] != t0 + 1) begin
      n_errors++;
      $display("FAIL post_reset_grant: got %h req%0d ready %b cycle %0d, expected 33 req1 010 %0d",
               got_d[0], got_id[0], got_rdy[0], got_cyc[0], t0 + 1);
    end
  endtask

  // Reference: whole messages in round-robin order starting from requester 0.
  task automatic test_random();
    bit tmo;
    logic [8:0] mq [NA][$];
    logic [7:0] exp_d[$];
    int         exp_id[$];
    logic       exp_l[$];
    logic [NA-1:0] er;
    logic [8:0] item;
    int ptr, nm, len, n;
    bit more, first;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      busy_len = $urandom_range(1, 8);
      busy_dly = 1'($urandom_range(0, 1));
      exp_d.delete(); exp_id.delete(); exp_l.delete();
      for (int r = 0; r < NA; r++) begin
        mq[r].delete();
        nm = (r == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            item = {(b == len - 1), 8'($urandom)};
            src_q[r].push_back(item);
            mq[r].push_back(item);
          end
        end
      end
      ptr = NA - 1;
      more = 1'b1;
      while (more) begin
        more = 1'b0;
        for (int k = 1; k <= NA; k++) begin
          n = (ptr + k) % NA;
          if (mq[n].size() > 0) begin
            first = 1'b1;
            do begin
              item = mq[n].pop_front();
              exp_d.push_back(item[7:0]); exp_id.push_back(n); exp_l.push_back(!first);
              first = 1'b0;
            end while (item[8] == 1'b0);
            ptr = n;
            more = 1'b1;
            break;
          end
        end
      end
      run_traffic(exp_d.size(), 2000, tmo);
      n_checks++;
      if (tmo || got_d.size() != exp_d.size()) begin
        n_errors++; $display("FAIL random_count[%0d]: got %0d bytes, expected %0d", it, got_d.size(), exp_d.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
        er = '0; er[exp_id[i]] = 1'b1;
        n_checks++;
        if (got_d[i] !== exp_d[i] || got_id[i] != exp_id[i] || got_lck[i] !== exp_l[i] ||
            got_rdy[i] !== er || got_busy[i] !== 1'b0) begin
          n_errors++;
          $display("FAIL random_byte[%0d.%0d]: got %h req%0d lck%b rdy%b busy%b, expected %h req%0d lck%b rdy%b busy0",
                   it, i, got_d[i], got_id[i], got_lck[i], got_rdy[i], got_busy[i], exp_d[i], exp_id[i], exp_l[i], er);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_lock_timeout();
    test_gap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
